// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - control stage driving the 32-slice one-bit ALU array
// Single-cycle R-type ops via one EXEC cycle; MULTU as a WIDTH-cycle shift-add on the ADD path.
module alu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       Signal,
    output logic             Binvert,
    output logic             cin0,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             overflow,
    output logic             zero,
    output logic             err
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam int         CW      = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        funct_q, funct_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;      // multiplier / LO during MUL
    logic [WIDTH-1:0]  acc_q, acc_d;  // HI accumulator during MUL
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              legal;
    logic              sub_op;
    logic              ovf;
    logic [WIDTH-1:0]  mul_hi;
    logic [WIDTH-1:0]  mul_lo;

    assign in_ready  = (state_q == S_IDLE) & ~reset;
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign hi        = hi_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            funct_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            funct_q <= funct_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        funct_d = funct_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        err_d   = err_q;
        alu_a   = '0;
        alu_b   = '0;
        Signal  = F_ADD;
        Binvert = 1'b0;
        cin0    = 1'b0;

        legal  = (funct_q == F_ADD) || (funct_q == F_SUB) || (funct_q == F_AND) ||
                 (funct_q == F_OR)  || (funct_q == F_SLT);
        sub_op = (funct_q == F_SUB) || (funct_q == F_SLT);
        ovf    = 1'b0;
        {mul_hi, mul_lo} = {alu_cout, alu_sum, b_q[WIDTH-1:1]};

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    funct_d = funct;
                    a_d     = dataA;
                    b_d     = dataB;
                    if (funct == F_MULTU) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_a   = a_q;
                alu_b   = b_q;
                Signal  = legal ? funct_q : F_ADD;
                Binvert = sub_op;
                cin0    = sub_op;
                ovf     = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_op)) &&
                          (alu_sum[WIDTH-1] != a_q[WIDTH-1]);
                hi_d    = '0;
                ovf_d   = 1'b0;
                err_d   = 1'b0;
                case (funct_q)
                    F_ADD, F_SUB: begin
                        res_d = alu_sum;
                        ovf_d = ovf;
                    end
                    F_AND, F_OR: res_d = alu_sum;
                    F_SLT:       res_d = {{(WIDTH-1){1'b0}}, alu_sum[WIDTH-1] ^ ovf};
                    default: begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                endcase
                zero_d  = (res_d == '0);
                state_d = S_DONE;
            end
            S_MUL: begin
                alu_a = acc_q;
                alu_b = b_q[0] ? a_q : '0;
                acc_d = mul_hi;
                b_d   = mul_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d   = mul_lo;
                    hi_d    = mul_hi;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    zero_d  = ({mul_hi, mul_lo} == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Buses fall back to the idle pattern whenever reset is asserted.
        if (reset) begin
            alu_a   = '0;
            alu_b   = '0;
            Signal  = F_ADD;
            Binvert = 1'b0;
            cin0    = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
// Slice array modelled combinationally; expected results from a plain arithmetic reference.
module tb_alu_seq_ctrl;

    localparam int W = 32;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   funct;
    logic [W-1:0] dataA, dataB;
    logic [W-1:0] alu_a, alu_b;
    logic [5:0]   Signal;
    logic         Binvert, cin0;
    logic [W-1:0] alu_sum;
    logic         alu_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, hi;
    logic         overflow, zero, err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .dataA(dataA), .dataB(dataB),
        .alu_a(alu_a), .alu_b(alu_b), .Signal(Signal),
        .Binvert(Binvert), .cin0(cin0),
        .alu_sum(alu_sum), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .hi(hi),
        .overflow(overflow), .zero(zero), .err(err)
    );

    // Slice array: logic ops bitwise, everything else through the ripple adder.
    logic [W:0] arr_s;
    always_comb begin
        arr_s    = '0;
        alu_sum  = '0;
        alu_cout = 1'b0;
        case (Signal)
            F_AND: alu_sum = alu_a & alu_b;
            F_OR:  alu_sum = alu_a | alu_b;
            default: begin
                arr_s    = {1'b0, alu_a} + {1'b0, alu_b ^ {W{Binvert}}} + {{W{1'b0}}, cin0};
                alu_sum  = arr_s[W-1:0];
                alu_cout = arr_s[W];
            end
        endcase
    end

    function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic [W-1:0] h,
                                   output logic o, output logic z, output logic e);
        longint sr;
        logic [63:0] p;
        r = '0; h = '0; o = 1'b0; e = 1'b0; sr = 0; p = '0;
        case (f)
            F_ADD: begin
                r  = a + b;
                sr = longint'($signed(a)) + longint'($signed(b));
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            F_SUB: begin
                r  = a - b;
                sr = longint'($signed(a)) - longint'($signed(b));
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_MULTU: begin
                p = 64'(a) * 64'(b);
                h = p[63:32];
                r = p[31:0];
            end
            default: e = 1'b1;
        endcase
        z = ({h, r} == 64'd0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency counts clock edges from the handshake cycle to the first cycle out_valid is seen.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] er, eh;
        logic eo, ez, ee, ebv;
        int cyc, w;
        ref_op(f, a, b, er, eh, eo, ez, ee);
        w = 0;
        while (!in_ready && w < 20) begin tick(); w++; end
        chk("ready_before", 64'(in_ready), 64'd1);
        funct = f; dataA = a; dataB = b; in_valid = 1'b1;
        tick();
        cyc = 1;
        in_valid = 1'b0;
        funct = 6'($urandom); dataA = $urandom; dataB = $urandom;
        chk("busy_ready", 64'(in_ready), 64'd0);
        if (f != F_MULTU) begin
            ebv = (f == F_SUB) || (f == F_SLT);
            chk("exec_binv", 64'(Binvert), 64'(ebv));
            chk("exec_cin0", 64'(cin0), 64'(ebv));
            chk("exec_a", 64'(alu_a), 64'(a));
            chk("exec_sig", 64'(Signal), 64'(ee ? F_ADD : f));
        end else begin
            chk("mul_first_a", 64'(alu_a), 64'd0);
            chk("mul_sig", 64'(Signal), 64'(F_ADD));
        end
        while (!out_valid && cyc < 60) begin tick(); cyc++; end
        chk("latency", 64'(cyc), (f == F_MULTU) ? 64'd33 : 64'd2);
        chk("result", 64'(result), 64'(er));
        chk("hi", 64'(hi), 64'(eh));
        chk("overflow", 64'(overflow), 64'(eo));
        chk("zero", 64'(zero), 64'(ez));
        chk("err", 64'(err), 64'(ee));
        chk("done_bus", {alu_a, 26'd0, Signal}, {32'd0, 26'd0, F_ADD});
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_out", {result, hi[27:0], overflow, zero, err, 1'b0},
                            {er, eh[27:0], eo, ez, ee, 1'b0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ret_valid", 64'(out_valid), 64'd0);
        chk("ret_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [5:0]   flist [7];
        logic [W-1:0] ra, rb;
        int           seen_valid;
        flist = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MULTU, 6'h3F};
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        funct = '0; dataA = '0; dataB = '0;
        tick(); tick();
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_out", {result, hi[27:0], overflow, zero, err, 1'b0}, 64'd0);
        chk("rst_bus", {alu_a, alu_b[23:0], Signal, Binvert, cin0}, {32'd0, 24'd0, F_ADD, 2'b00});
        reset = 1'b0;
        #1;
        chk("idle_ready", 64'(in_ready), 64'd1);

        do_op(F_ADD, 32'd7, 32'd5, 0);
        chk("add_7_5", 64'(result), 64'd12);
        do_op(F_SUB, 32'd5, 32'd7, 0);
        chk("sub_5_7", 64'(result), 64'hFFFF_FFFE);
        do_op(F_ADD, 32'h7FFF_FFFF, 32'd1, 0);
        chk("add_ovf", 64'(overflow), 64'd1);
        do_op(F_SUB, 32'd3, 32'd3, 0);
        chk("sub_zero", 64'(zero), 64'd1);
        do_op(F_SLT, 32'h8000_0000, 32'd1, 0);
        chk("slt_neg", 64'(result), 64'd1);
        do_op(F_SLT, 32'd1, 32'h8000_0000, 0);
        chk("slt_pos", 64'(result), 64'd0);
        do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("mul_max", {hi, result}, 64'hFFFF_FFFE_0000_0001);
        do_op(F_MULTU, 32'd6, 32'd7, 0);
        chk("mul_6_7", {hi, result}, 64'd42);
        do_op(F_OR, 32'hF0F0_0000, 32'h0000_0F0F, 10);
        do_op(6'h3F, 32'd9, 32'd9, 0);
        chk("illegal", {31'd0, err, result}, {31'd0, 1'b1, 32'd0});

        for (int n = 0; n < 24; n++) begin
            ra = (n % 5 == 0) ? 32'h8000_0000 : $urandom;
            rb = (n % 7 == 0) ? 32'h7FFF_FFFF : $urandom;
            do_op(flist[$urandom_range(0, 6)], ra, rb, $urandom_range(0, 3));
        end

        // Reset in the middle of a multiply: result is dropped, block returns to idle.
        funct = F_MULTU; dataA = 32'h1234_5678; dataB = 32'h9ABC_DEF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("midrst_ready", 64'(in_ready), 64'd0);
        chk("midrst_bus", {alu_a, alu_b[23:0], Signal, Binvert, cin0}, {32'd0, 24'd0, F_ADD, 2'b00});
        tick();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_out", {result, hi[27:0], overflow, zero, err, 1'b0}, 64'd0);
        reset = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen_valid++;
        end
        chk("midrst_no_valid", 64'(seen_valid), 64'd0);
        chk("midrst_idle", 64'(in_ready), 64'd1);
        do_op(F_ADD, 32'd100, 32'd23, 0);
        chk("post_rst_add", 64'(result), 64'd123);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential control stage that sits directly upstream of the 32-slice one-bit ALU array. It accepts an operation request (MIPS R-type funct plus two operands) over a valid/ready handshake and drives the array's shared Signal, Binvert, bit-0 carry-in and operand buses. It captures the array's combinational sum and carry-out, forms SLT, overflow and zero, and holds the result until the consumer takes it. It also runs MULTU as a WIDTH-cycle shift-add loop that reuses the array's ADD path.

## Interface
- WIDTH, 32, operand/result width; equals slice count in the array.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; = (state==IDLE) & ~reset.
- funct  in  6  100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 011001 MULTU; anything else is illegal.
- dataA, dataB  in  WIDTH  operands (MULTU: multiplicand A, multiplier B).
- alu_a, alu_b  out  WIDTH  operand buses to the slice array.
- Signal  out  6  function code broadcast to every slice.
- Binvert  out  1  broadcast B-invert.
- cin0  out  1  carry into slice 0.
- alu_sum  in  WIDTH  slice sum outputs; combinational from alu_a/alu_b/controls.
- alu_cout  in  1  carry out of slice WIDTH-1.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- result  out  WIDTH  main result (MULTU: LO).
- hi  out  WIDTH  MULTU high word; 0 otherwise.
- overflow, zero, err  out  1  flags for the held result.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: in_valid & in_ready latches funct, dataA, dataB. MULTU goes to MUL with counter = 0, HI = 0, LO = dataB. All other functs go to EXEC.
- EXEC (1 cycle): drive alu_a = A and alu_b = B.
  - Signal = funct for legal ops, 100000 for illegal.
  - Binvert = cin0 = 1 for SUB and SLT, else 0.
  - Capture at cycle end, then go to DONE.
- Captured result per op:
  - ADD, SUB, AND, OR: alu_sum.
  - SLT: {WIDTH-1 zeros, alu_sum[MSB] ^ ovf}.
  - Illegal: result 0, err = 1.
- ovf is two's-complement overflow: A[MSB] == (B^Binvert)[MSB] and alu_sum[MSB] differs from it. The overflow output equals ovf for ADD and SUB; it is 0 for AND, OR, SLT, MULTU and illegal ops.
- MUL, per cycle:
  - Drive alu_a = HI, alu_b = LO[0] ? A : 0, Signal = 100000, Binvert = cin0 = 0.
  - At the edge: {HI, LO} <= {alu_cout, alu_sum, LO[WIDTH-1:1]}, counter++.
  - After WIDTH iterations go to DONE with result = LO, hi = HI.
- zero: result == 0 (MULTU: {hi, result} == 0).
- DONE: out_valid = 1; result and flags held stable. out_ready returns to IDLE.
- IDLE, DONE and reset drive: alu_a = alu_b = 0, Signal = 100000, Binvert = cin0 = 0.
- Unsigned MULTU only; the product is exactly 2*WIDTH bits and cannot overflow.

## Timing
- Reset values: state IDLE; out_valid, result, hi, overflow, zero, err all 0; bus outputs as in IDLE; in_ready = 0 while reset is high.
- Single-cycle ops: accept at edge N; EXEC during cycle N+1; out_valid high from edge N+2. Latency 2.
- MULTU: accept at edge N; MUL during cycles N+1..N+WIDTH; out_valid from edge N+WIDTH+1. Latency WIDTH+1.
- in_ready is low in EXEC, MUL and DONE. There is no accept in the same cycle as out_valid&out_ready; the next accept is possible one cycle later.
- Backpressure: while out_valid & ~out_ready, all outputs are held indefinitely.
- Reset in any state, including mid-MUL or DONE: next edge goes to IDLE with reset values. The result is discarded and out_valid is never asserted for it.
- in_valid while not ready is ignored. Input data is sampled only at the accept edge; later input changes do not affect an op in flight.

## Test plan
The bench models the slice array combinationally.
- ADD 7 + 5 -> result 12, overflow 0, zero 0, out_valid 2 cycles after accept.
- SUB 5 - 7 -> result 0xFFFFFFFE, overflow 0. ADD 0x7FFFFFFF + 1 -> 0x80000000, overflow 1. SUB 3 - 3 -> zero 1.
- SLT A = 0x80000000, B = 1 -> result 1. SLT A = 1, B = 0x80000000 -> result 0. During EXEC: Binvert = 1 and cin0 = 1.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi 0xFFFFFFFE, result 0x00000001, out_valid exactly 33 cycles after accept. MULTU 6 * 7 -> hi 0, result 42.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE -> outputs stable and in_ready = 0; one cycle of out_ready -> IDLE and in_ready = 1. Illegal funct 0x3F -> err 1, result 0.
- Assert reset at MUL cycle 10 -> IDLE next edge, all outputs at reset values, no out_valid; a new ADD then completes normally.
